// File: rtl/iram_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iram_prog_pkg
// Brief    : Shared encodings and widths for the IRAM programming sequencer.
// Revision : 1.0
// ============================================================================
package iram_prog_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int WORD_CNT_W      = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [WORD_CNT_W-1:0] sat_inc(input logic [WORD_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Brief    : Multi-flop synchroniser with a registered rising-edge pulse.
// Revision : 1.0
// ============================================================================
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], din};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
        end
    end

    assign level = r_sync[STAGES-1];
    assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/iram_prog_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iram_prog_ctrl
// Brief    : Assembles pad byte strobes into IRAM writes and gates fetch.
// Revision : 1.0
// ============================================================================
module iram_prog_ctrl
    import iram_prog_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            iram_prog_byte,
    input  logic [1:0]            iram_prog_byte_idx,
    input  logic                  iram_prog_data_byte,
    input  logic                  iram_prog_addr_byte,
    input  logic                  iram_prog_wr,
    input  logic                  fetch_en_req,
    output logic                  iram_we_o,
    output logic [ADDR_W-1:0]     iram_addr_o,
    output logic [DATA_W-1:0]     iram_wdata_o,
    input  logic                  iram_ready_i,
    output logic                  fetch_enable_o,
    output logic                  prog_busy_o,
    output logic                  prog_err_o,
    output logic [WORD_CNT_W-1:0] word_cnt_o
);

    // Only four byte lanes are addressable through the 2-bit index.
    localparam int ADDR_LANES = (ADDR_W / 8 < 4) ? ADDR_W / 8 : 4;
    localparam int DATA_LANES = (DATA_W / 8 < 4) ? DATA_W / 8 : 4;

    logic                  w_data_rise;
    logic                  w_addr_rise;
    logic                  w_wr_rise;
    logic                  w_fetch_lvl;
    logic [3:0]            w_unused_sig;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  w_start;
    logic                  w_err_set;
    logic                  w_cnt_inc;

    logic [ADDR_W-1:0]     r_addr_sh;
    logic [DATA_W-1:0]     r_data_sh;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_err;
    logic                  r_fetch_en;
    logic [WORD_CNT_W-1:0] r_word_cnt;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (iram_prog_data_byte),
        .level (w_unused_sig[0]),
        .rise  (w_data_rise)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (iram_prog_addr_byte),
        .level (w_unused_sig[1]),
        .rise  (w_addr_rise)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_wr (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (iram_prog_wr),
        .level (w_unused_sig[2]),
        .rise  (w_wr_rise)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_fetch (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (fetch_en_req),
        .level (w_fetch_lvl),
        .rise  (w_unused_sig[3])
    );

    // A commit is honoured only from IDLE with the core not fetching.
    assign w_start   = w_wr_rise && (r_state == ST_IDLE) && !r_fetch_en;
    assign w_err_set = (w_wr_rise && !w_start) || (w_start && (r_addr_sh[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_next = ST_WRITE;
            ST_WRITE: if (iram_ready_i) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        iram_we_o   = (r_state == ST_WRITE);
        prog_busy_o = (r_state != ST_IDLE);
        w_cnt_inc   = (r_state == ST_DONE);
    end

    // Shadows persist across commits so unchanged bytes can be reused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_sh <= '0;
            r_data_sh <= '0;
        end else begin
            for (int i = 0; i < ADDR_LANES; i++) begin
                if (w_addr_rise && (int'(iram_prog_byte_idx) == i)) begin
                    r_addr_sh[8*i +: 8] <= iram_prog_byte;
                end
            end
            for (int i = 0; i < DATA_LANES; i++) begin
                if (w_data_rise && (int'(iram_prog_byte_idx) == i)) begin
                    r_data_sh[8*i +: 8] <= iram_prog_byte;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_fetch_en <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            if (w_start) begin
                r_addr  <= {r_addr_sh[ADDR_W-1:2], 2'b00};
                r_wdata <= r_data_sh;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            r_fetch_en <= w_fetch_lvl && (r_state == ST_IDLE) && !w_start;
            if (w_cnt_inc) begin
                r_word_cnt <= sat_inc(r_word_cnt);
            end
        end
    end

    assign iram_addr_o    = r_addr;
    assign iram_wdata_o   = r_wdata;
    assign prog_err_o     = r_err;
    assign fetch_enable_o = r_fetch_en;
    assign word_cnt_o     = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_iram_prog_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iram_prog_ctrl
// Brief    : Randomised self-checking bench for iram_prog_ctrl.
// Revision : 1.0
// ============================================================================
module tb_iram_prog_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  iram_prog_byte = 8'h00;
    logic [1:0]  iram_prog_byte_idx = 2'd0;
    logic        iram_prog_data_byte = 1'b0;
    logic        iram_prog_addr_byte = 1'b0;
    logic        iram_prog_wr = 1'b0;
    logic        fetch_en_req = 1'b0;
    logic        iram_we_o;
    logic [31:0] iram_addr_o;
    logic [31:0] iram_wdata_o;
    logic        iram_ready_i = 1'b1;
    logic        fetch_enable_o;
    logic        prog_busy_o;
    logic        prog_err_o;
    logic [15:0] word_cnt_o;

    always #5 clk = ~clk;

    iram_prog_ctrl #(.ADDR_W(32), .DATA_W(32), .SYNC_STAGES(S)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .iram_prog_byte      (iram_prog_byte),
        .iram_prog_byte_idx  (iram_prog_byte_idx),
        .iram_prog_data_byte (iram_prog_data_byte),
        .iram_prog_addr_byte (iram_prog_addr_byte),
        .iram_prog_wr        (iram_prog_wr),
        .fetch_en_req        (fetch_en_req),
        .iram_we_o           (iram_we_o),
        .iram_addr_o         (iram_addr_o),
        .iram_wdata_o        (iram_wdata_o),
        .iram_ready_i        (iram_ready_i),
        .fetch_enable_o      (fetch_enable_o),
        .prog_busy_o         (prog_busy_o),
        .prog_err_o          (prog_err_o),
        .word_cnt_o          (word_cnt_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: byte-lane shadows, queue of expected writes, sticky error, count.
    logic [31:0] m_addr_sh = '0;
    logic [31:0] m_data_sh = '0;
    logic        m_err = 1'b0;
    int          m_cnt = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          ready_mode = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       iram_ready_i = 1'b1;
                1:       iram_ready_i = 1'($urandom_range(0, 1));
                default: iram_ready_i = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n && iram_we_o && iram_ready_i) begin
            check("write_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) begin
                check("wr_addr", 64'(iram_addr_o), 64'(exp_addr_q.pop_front()));
                check("wr_data", 64'(iram_wdata_o), 64'(exp_data_q.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pad_byte(input bit is_data, input bit is_addr, input logic [1:0] idx, input logic [7:0] b);
        iram_prog_byte     = b;
        iram_prog_byte_idx = idx;
        cyc(1);
        iram_prog_data_byte = is_data;
        iram_prog_addr_byte = is_addr;
        cyc(5);
        iram_prog_data_byte = 1'b0;
        iram_prog_addr_byte = 1'b0;
        cyc(5);
        if (is_data) m_data_sh[8*idx +: 8] = b;
        if (is_addr) m_addr_sh[8*idx +: 8] = b;
    endtask

    task automatic pad_wr(input bit accept, input bit measure);
        int lat;
        if (accept) begin
            exp_addr_q.push_back({m_addr_sh[31:2], 2'b00});
            exp_data_q.push_back(m_data_sh);
            if (m_addr_sh[1:0] != 2'b00) m_err = 1'b1;
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end else begin
            m_err = 1'b1;
        end
        iram_prog_wr = 1'b1;
        if (accept) begin
            lat = 0;
            while (!iram_we_o && lat < 20) begin
                @(posedge clk);
                lat++;
                #1;
            end
            check("wr_seen", 64'(iram_we_o), 64'd1);
            if (measure) check("wr_latency", 64'(lat), 64'(S + 2));
            @(negedge clk);
            cyc(2);
        end else begin
            cyc(6);
        end
        iram_prog_wr = 1'b0;
        cyc(5);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (prog_busy_o && n < 300) begin
            cyc(1);
            n++;
        end
        check("idle_reached", 64'(prog_busy_o), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    64'(iram_we_o),      64'd0);
        check({tag, "_addr"},  64'(iram_addr_o),    64'd0);
        check({tag, "_data"},  64'(iram_wdata_o),   64'd0);
        check({tag, "_busy"},  64'(prog_busy_o),    64'd0);
        check({tag, "_err"},   64'(prog_err_o),     64'd0);
        check({tag, "_fetch"}, 64'(fetch_enable_o), 64'd0);
        check({tag, "_cnt"},   64'(word_cnt_o),     64'd0);
    endtask

    initial begin
        int          nb, kind, lat;
        logic [7:0]  b;
        logic [1:0]  idx;
        logic [31:0] held_addr, held_data;
        bit          seen_high, stable;

        cyc(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc(2);

        // Program one word from the documented byte sequence.
        pad_byte(0, 1, 2'd0, 8'h00);
        pad_byte(0, 1, 2'd1, 8'h01);
        pad_byte(0, 1, 2'd2, 8'h00);
        pad_byte(0, 1, 2'd3, 8'h00);
        pad_byte(1, 0, 2'd0, 8'h93);
        pad_byte(1, 0, 2'd1, 8'h00);
        pad_byte(1, 0, 2'd2, 8'h10);
        pad_byte(1, 0, 2'd3, 8'h00);
        check("model_word", 64'({m_addr_sh, m_data_sh}), 64'h00000100_00100093);
        pad_wr(1, 1);
        wait_idle();
        check("one_word_cnt", 64'(word_cnt_o), 64'd1);
        check("one_word_err", 64'(prog_err_o), 64'd0);

        // Ready stall: request and payload must hold while ready is low.
        ready_mode = 2;
        pad_byte(1, 0, 2'd0, 8'h5A);
        pad_wr(1, 0);
        held_addr = iram_addr_o;
        held_data = iram_wdata_o;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (!iram_we_o || !prog_busy_o || iram_addr_o != held_addr || iram_wdata_o != held_data)
                stable = 1'b0;
        end
        check("stall_stable", 64'(stable), 64'd1);
        check("stall_cnt_held", 64'(word_cnt_o), 64'd1);
        ready_mode = 0;
        wait_idle();
        check("stall_cnt", 64'(word_cnt_o), 64'(m_cnt));

        // Randomised words with random ready.
        ready_mode = 1;
        for (int w = 0; w < 12; w++) begin
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                kind = $urandom_range(0, 2);
                b    = 8'($urandom);
                idx  = 2'($urandom);
                if (kind != 0 && idx == 2'd0 && $urandom_range(0, 3) != 0) b[1:0] = 2'b00;
                pad_byte(kind != 1, kind != 0, idx, b);
            end
            pad_wr(1, 0);
            wait_idle();
            check("rnd_cnt", 64'(word_cnt_o), 64'(m_cnt));
            check("rnd_err", 64'(prog_err_o), 64'(m_err));
        end

        // Fetch gating while a write is stalled, then a rejected commit.
        ready_mode = 2;
        pad_byte(1, 0, 2'd3, 8'hC3);
        pad_wr(1, 0);
        fetch_en_req = 1'b1;
        seen_high = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (fetch_enable_o) seen_high = 1'b1;
        end
        check("fetch_gated", 64'(seen_high), 64'd0);
        ready_mode = 0;
        wait_idle();
        lat = 0;
        while (!fetch_enable_o && lat < 10) begin
            cyc(1);
            lat++;
        end
        check("fetch_rises", 64'(fetch_enable_o), 64'd1);
        pad_wr(0, 0);
        check("fetch_reject_err", 64'(prog_err_o), 64'd1);
        check("fetch_reject_cnt", 64'(word_cnt_o), 64'(m_cnt));
        check("fetch_reject_busy", 64'(prog_busy_o), 64'd0);
        fetch_en_req = 1'b0;
        cyc(6);
        check("fetch_drops", 64'(fetch_enable_o), 64'd0);
        fetch_en_req = 1'b1;
        lat = 0;
        while (!fetch_enable_o && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("fetch_latency", 64'(lat), 64'(S + 1));
        @(negedge clk);
        fetch_en_req = 1'b0;
        cyc(6);

        // Reset in the middle of a stalled write.
        ready_mode = 2;
        pad_byte(0, 1, 2'd2, 8'h77);
        pad_wr(1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        void'(exp_addr_q.pop_back());
        void'(exp_data_q.pop_back());
        m_addr_sh = '0;
        m_data_sh = '0;
        m_err = 1'b0;
        m_cnt = 0;
        ready_mode = 0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        pad_wr(1, 0);
        wait_idle();
        check("post_rst_cnt", 64'(word_cnt_o), 64'(m_cnt));

        // Misaligned address, plus a commit that lands during the stall.
        ready_mode = 2;
        pad_byte(0, 1, 2'd0, 8'h03);
        pad_byte(0, 1, 2'd1, 8'($urandom));
        pad_wr(1, 0);
        check("misalign_err", 64'(prog_err_o), 64'd1);
        pad_wr(0, 0);
        ready_mode = 0;
        wait_idle();
        check("misalign_cnt", 64'(word_cnt_o), 64'(m_cnt));

        // Saturation: preload the counter near the top, then keep writing.
        cyc(2);
        force dut.r_word_cnt = 16'hFFFC;
        cyc(1);
        release dut.r_word_cnt;
        m_cnt = 16'hFFFC;
        cyc(1);
        check("preload_cnt", 64'(word_cnt_o), 64'(m_cnt));
        for (int i = 0; i < 5; i++) begin
            pad_byte(1, 0, 2'(i), 8'($urandom));
            pad_wr(1, 0);
            wait_idle();
            check("sat_cnt", 64'(word_cnt_o), 64'(m_cnt));
        end
        check("sat_final", 64'(word_cnt_o), 64'hFFFF);

        cyc(4);
        check("queue_drained", 64'(exp_addr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
